// File: rtl/pdp8_pkg.sv
// Shared PDP-8 definitions: word/address widths, start address and the
// memory responder state enum so checkers can name the states.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp8_pkg;

  localparam int ADDR_WIDTH = `ADDR_WIDTH;
  localparam int DATA_WIDTH = `DATA_WIDTH;

  // Conventional PDP-8 program start address (octal 200)
  localparam logic [ADDR_WIDTH-1:0] START_ADDRESS = ADDR_WIDTH'('o200);

  typedef enum logic [1:0] {
    CLEAR,
    LOAD,
    RUN
  } mem_state_e;

endpackage

// File: rtl/pdp8_mem_array.sv
// 2**ADDR_WIDTH x DATA_WIDTH storage with one write port and two
// synchronous read ports. Reads return the contents before a same-cycle
// write. Read registers hold until the next enabled read on their port.
module pdp8_mem_array #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_a_en,
  input  logic [ADDR_WIDTH-1:0] rd_a_addr,
  output logic [DATA_WIDTH-1:0] rd_a_data,
  input  logic                  rd_b_en,
  input  logic [ADDR_WIDTH-1:0] rd_b_addr,
  output logic [DATA_WIDTH-1:0] rd_b_data
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage write; no reset, the top sweeps zeros in after every reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port A register; non-blocking read gives read-before-write
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n)      rd_a_data <= '0;
    else if (rd_a_en) rd_a_data <= mem[rd_a_addr];
  end

  // Read port B register; same behaviour as port A
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n)      rd_b_data <= '0;
    else if (rd_b_en) rd_b_data <= mem[rd_b_addr];
  end

endmodule

// File: rtl/pdp8_mem_responder.sv
// PDP-8 memory responder: clears memory after reset, accepts a program
// image on the load port, then serves IFD fetches and EXEC reads/writes
// with one-cycle read latency. Illegal requests are dropped and flagged.
module pdp8_mem_responder #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_done,
  output logic                  mem_ready,
  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic [DATA_WIDTH-1:0] ifu_rd_data,
  input  logic                  exec_rd_req,
  input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
  output logic [DATA_WIDTH-1:0] exec_rd_data,
  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic                  req_err
);

  import pdp8_pkg::*;

  mem_state_e            state, state_next;
  logic [ADDR_WIDTH-1:0] sweep_cnt, sweep_next;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  ifu_en, exec_en;
  logic                  err_next;

  // Next state, sweep counter, write-source mux and error detection
  always_comb begin
    state_next = state;
    sweep_next = sweep_cnt;
    wr_en      = 1'b0;
    wr_addr    = sweep_cnt;
    wr_data    = '0;
    ifu_en     = 1'b0;
    exec_en    = 1'b0;
    err_next   = 1'b0;
    case (state)
      CLEAR: begin
        wr_en      = 1'b1;
        sweep_next = sweep_cnt + 1'b1;
        err_next   = ifu_rd_req | exec_rd_req | exec_wr_req | load_en;
        if (&sweep_cnt) state_next = LOAD;
      end
      LOAD: begin
        wr_en    = load_en;
        wr_addr  = load_addr;
        wr_data  = load_data;
        err_next = ifu_rd_req | exec_rd_req | exec_wr_req;
        if (load_done) state_next = RUN;
      end
      RUN: begin
        wr_en    = exec_wr_req;
        wr_addr  = exec_wr_addr;
        wr_data  = exec_wr_data;
        ifu_en   = ifu_rd_req;
        exec_en  = exec_rd_req;
        err_next = load_en;
      end
      default: state_next = CLEAR;
    endcase
  end

  // State, sweep counter and registered error pulse
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state     <= CLEAR;
      sweep_cnt <= '0;
      req_err   <= 1'b0;
    end else begin
      state     <= state_next;
      sweep_cnt <= sweep_next;
      req_err   <= err_next;
    end
  end

  assign mem_ready = (state == RUN);

  pdp8_mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_a_en  (ifu_en),
    .rd_a_addr(ifu_rd_addr),
    .rd_a_data(ifu_rd_data),
    .rd_b_en  (exec_en),
    .rd_b_addr(exec_rd_addr),
    .rd_b_data(exec_rd_data)
  );

endmodule

// File: tb/tb_pdp8_mem_responder.sv
// Self-checking bench for pdp8_mem_responder: directed scenarios plus
// randomized RUN traffic, checked every cycle against a word-array model.
module tb_pdp8_mem_responder;

  import pdp8_pkg::*;

  localparam int AW    = 12;
  localparam int DW    = 12;
  localparam int DEPTH = 4096;

  localparam int P_CLEAR = 0;
  localparam int P_LOAD  = 1;
  localparam int P_RUN   = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;
  logic          load_done = 1'b0;
  logic          mem_ready;
  logic          ifu_rd_req = 1'b0;
  logic [AW-1:0] ifu_rd_addr = '0;
  logic [DW-1:0] ifu_rd_data;
  logic          exec_rd_req = 1'b0;
  logic [AW-1:0] exec_rd_addr = '0;
  logic [DW-1:0] exec_rd_data;
  logic          exec_wr_req = 1'b0;
  logic [AW-1:0] exec_wr_addr = '0;
  logic [DW-1:0] exec_wr_data = '0;
  logic          req_err;

  int n_checks = 0;
  int n_pass   = 0;

  int model_mem [DEPTH];
  int phase;
  int clear_cnt;
  int exp_ifu, exp_exec, exp_err;

  pdp8_mem_responder dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_done   (load_done),
    .mem_ready   (mem_ready),
    .ifu_rd_req  (ifu_rd_req),
    .ifu_rd_addr (ifu_rd_addr),
    .ifu_rd_data (ifu_rd_data),
    .exec_rd_req (exec_rd_req),
    .exec_rd_addr(exec_rd_addr),
    .exec_rd_data(exec_rd_data),
    .exec_wr_req (exec_wr_req),
    .exec_wr_addr(exec_wr_addr),
    .exec_wr_data(exec_wr_data),
    .req_err     (req_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  task automatic idle_inputs();
    load_en     = 1'b0;
    load_done   = 1'b0;
    ifu_rd_req  = 1'b0;
    exec_rd_req = 1'b0;
    exec_wr_req = 1'b0;
  endtask

  // One clock: update the model from the current inputs, then compare
  task automatic apply_stimulus();
    int err;
    err = 0;
    if (phase == P_CLEAR) begin
      if (ifu_rd_req || exec_rd_req || exec_wr_req || load_en) err = 1;
      clear_cnt++;
      if (clear_cnt == DEPTH) phase = P_LOAD;
    end else if (phase == P_LOAD) begin
      if (ifu_rd_req || exec_rd_req || exec_wr_req) err = 1;
      if (load_en) model_mem[load_addr] = int'(load_data);
      if (load_done) phase = P_RUN;
    end else begin
      if (load_en) err = 1;
      if (ifu_rd_req)  exp_ifu  = model_mem[ifu_rd_addr];
      if (exec_rd_req) exp_exec = model_mem[exec_rd_addr];
      if (exec_wr_req) model_mem[exec_wr_addr] = int'(exec_wr_data);
    end
    exp_err = err;
    @(posedge clk);
    #1;
    check_output("ifu_rd_data", 32'(ifu_rd_data), 32'(exp_ifu));
    check_output("exec_rd_data", 32'(exec_rd_data), 32'(exp_exec));
    check_output("req_err", 32'(req_err), 32'(exp_err));
    check_output("mem_ready", 32'(mem_ready), 32'(phase == P_RUN));
    idle_inputs();
  endtask

  task automatic do_reset();
    reset_n = 1'b1;
    #1;
    check_output("rst_ifu", 32'(ifu_rd_data), 32'd0);
    check_output("rst_exec", 32'(exec_rd_data), 32'd0);
    check_output("rst_err", 32'(req_err), 32'd0);
    check_output("rst_ready", 32'(mem_ready), 32'd0);
    foreach (model_mem[i]) model_mem[i] = 0;
    phase     = P_CLEAR;
    clear_cnt = 0;
    exp_ifu   = 0;
    exp_exec  = 0;
    exp_err   = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    apply_stimulus();
  endtask

  task automatic ifu_read(input logic [AW-1:0] a);
    ifu_rd_req  = 1'b1;
    ifu_rd_addr = a;
  endtask

  task automatic exec_read(input logic [AW-1:0] a);
    exec_rd_req  = 1'b1;
    exec_rd_addr = a;
  endtask

  task automatic exec_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exec_wr_req  = 1'b1;
    exec_wr_addr = a;
    exec_wr_data = d;
  endtask

  // Run the sweep; an illegal fetch early on, an illegal load on the last cycle
  task automatic run_clear(input bit with_errors);
    for (int c = 0; c < DEPTH; c++) begin
      if (with_errors && c == 10) ifu_read(12'o0300);
      if (with_errors && c == DEPTH - 1) load_word(12'o0400, 12'o4444);
      else apply_stimulus();
      if (c == DEPTH - 2) check_output("fsm_clear", 32'(dut.state), 32'(CLEAR));
    end
    check_output("fsm_load", 32'(dut.state), 32'(LOAD));
  endtask

  initial begin
    idle_inputs();
    #1;
    $display("[TB] start");
    do_reset();
    run_clear(1'b1);

    // Load phase with an illegal write, then load_en together with load_done
    load_word(12'o0200, 12'o7402);
    load_word(12'o7777, 12'o1234);
    exec_write(12'o0300, 12'o7777);
    apply_stimulus();
    load_word(12'o0201, 12'o1111);
    load_done = 1'b1;
    load_word(12'o0202, 12'o2222);

    // Loaded words not re-read: read data must hold zero
    repeat (3) apply_stimulus();

    // Fetch and operand read in the same cycle
    ifu_read(12'o0200);
    exec_read(12'o7777);
    apply_stimulus();
    check_output("ifu_o200", 32'(ifu_rd_data), 32'o7402);
    check_output("exec_o7777", 32'(exec_rd_data), 32'o1234);

    // Illegal load writes during CLEAR/LOAD left their targets untouched
    ifu_read(12'o0400);
    exec_read(12'o0202);
    apply_stimulus();
    check_output("ifu_o400_clr", 32'(ifu_rd_data), 32'd0);
    check_output("exec_o202", 32'(exec_rd_data), 32'o2222);

    // Read-before-write collision, then the new value is visible
    exec_write(12'o0300, 12'o5555);
    ifu_read(12'o0300);
    apply_stimulus();
    check_output("rbw_old", 32'(ifu_rd_data), 32'd0);
    ifu_read(12'o0300);
    apply_stimulus();
    check_output("rbw_new", 32'(ifu_rd_data), 32'o5555);

    // load_en in RUN flags an error; load_done in RUN is silent; data holds
    load_done = 1'b1;
    load_word(12'o0300, 12'o0001);
    repeat (2) apply_stimulus();
    exec_read(12'o0300);
    apply_stimulus();
    check_output("run_load_ignored", 32'(exec_rd_data), 32'o5555);

    // Random RUN traffic on a narrow window to force collisions
    for (int i = 0; i < 400; i++) begin
      ifu_rd_req   = 1'($urandom);
      ifu_rd_addr  = 12'o0200 + 12'($urandom_range(0, 7));
      exec_rd_req  = 1'($urandom);
      exec_rd_addr = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'o0200 + 12'($urandom_range(0, 7));
      exec_wr_req  = 1'($urandom);
      exec_wr_addr = 12'o0200 + 12'($urandom_range(0, 7));
      exec_wr_data = 12'($urandom);
      load_en      = ($urandom_range(0, 9) == 0);
      load_addr    = 12'($urandom);
      load_data    = 12'($urandom);
      load_done    = ($urandom_range(0, 9) == 0);
      apply_stimulus();
    end

    // Reset mid-LOAD: memory is swept again and the old load is lost
    do_reset();
    run_clear(1'b0);
    load_word(12'o0200, 12'o7402);
    apply_stimulus();
    #2;
    do_reset();
    run_clear(1'b0);
    load_done = 1'b1;
    apply_stimulus();
    ifu_read(12'o0200);
    exec_read(12'o0200);
    apply_stimulus();
    check_output("reload_o200", 32'(ifu_rd_data), 32'd0);

    // Random LOAD-phase traffic after another reset, then random RUN reads
    do_reset();
    run_clear(1'b0);
    for (int i = 0; i < 60; i++) begin
      load_en     = 1'($urandom);
      load_addr   = 12'o0200 + 12'($urandom_range(0, 15));
      load_data   = 12'($urandom);
      ifu_rd_req  = ($urandom_range(0, 7) == 0);
      exec_wr_req = ($urandom_range(0, 7) == 0);
      exec_wr_addr = 12'o0200 + 12'($urandom_range(0, 15));
      exec_wr_data = 12'($urandom);
      apply_stimulus();
    end
    load_done = 1'b1;
    apply_stimulus();
    for (int i = 0; i < 40; i++) begin
      ifu_read(12'o0200 + 12'($urandom_range(0, 15)));
      exec_read(12'o0200 + 12'($urandom_range(0, 15)));
      apply_stimulus();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pdp8_mem_responder.md
# pdp8_mem_responder

Memory-side responder for the PDP-8 instruction fetch and execute read/write interfaces. It owns the 4K x 12-bit main memory, clears it after reset, accepts a program image through a load port, then serves IFD fetches (`ifu_rd_*`) and execution-unit reads and writes (`exec_rd_*`, `exec_wr_*`) with fixed one-cycle read latency. It sits between IFD/EXEC and the testbench program loader.

## Interface
- `ADDR_WIDTH`, default `` `ADDR_WIDTH `` (12): word address width; depth = 2**ADDR_WIDTH.
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (12): word width.

Ports (name, direction, width, meaning):
- `clk`  in  1  clock.
- `reset_n`  in  1  reset; asynchronous, active-high (1 = reset asserted).
- `load_en`  in  1  write `load_data` to `load_addr`; honoured in LOAD only.
- `load_addr`  in  ADDR_WIDTH  load address.
- `load_data`  in  DATA_WIDTH  load word.
- `load_done`  in  1  one-cycle pulse ending the load phase.
- `mem_ready`  out  1  high only in RUN.
- `ifu_rd_req`  in  1  IFD fetch request.
- `ifu_rd_addr`  in  ADDR_WIDTH  fetch address.
- `ifu_rd_data`  out  DATA_WIDTH  fetched word.
- `exec_rd_req`  in  1  EXEC operand read request.
- `exec_rd_addr`  in  ADDR_WIDTH  read address.
- `exec_rd_data`  out  DATA_WIDTH  read word.
- `exec_wr_req`  in  1  EXEC write request.
- `exec_wr_addr`  in  ADDR_WIDTH  write address.
- `exec_wr_data`  in  DATA_WIDTH  write word.
- `req_err`  out  1  one-cycle pulse: a request arrived outside its legal state.

## Operation
- FSM states: CLEAR, LOAD, RUN.
- CLEAR (entered on reset): a sweep counter writes 0 to addresses 0 through 2**ADDR_WIDTH-1, one word per cycle. The cycle that writes the last address transitions to LOAD. The counter wraps only through that transition.
- LOAD: each `load_en` cycle writes `load_data` to `load_addr`. A `load_done` pulse moves the FSM to RUN. If `load_en` and `load_done` arrive in the same cycle, the write is performed and then the FSM moves to RUN.
- RUN: remains in RUN until reset. Each cycle serves all three ports:
  - `ifu_rd_req` reads `ifu_rd_addr` into `ifu_rd_data`.
  - `exec_rd_req` reads `exec_rd_addr` into `exec_rd_data`.
  - `exec_wr_req` writes `exec_wr_data` to `exec_wr_addr`.
- Same-address collision in the same cycle: reads return the old contents (read-before-write). The new value is visible from the next cycle.
- Read data registers hold their value until the next accepted read on the same port.
- Illegal requests: `ifu_rd_req`, `exec_rd_req` or `exec_wr_req` outside RUN, or `load_en` outside LOAD.
  - The request is ignored: no write occurs and read data is not updated.
  - `req_err` pulses the next cycle, once per offending cycle (OR of all offences).
- `load_done` outside LOAD is ignored silently.

## Timing
- Reset values: `ifu_rd_data`=0, `exec_rd_data`=0, `mem_ready`=0, `req_err`=0. FSM=CLEAR, sweep counter=0.
- Asserting `reset_n` at any point, including mid-sweep, mid-load or during RUN, forces the above immediately. The memory is re-cleared after reset deasserts.
- The CLEAR sweep starts at the first posedge with reset deasserted and lasts exactly 2**ADDR_WIDTH cycles (4096 at default width).
- `mem_ready` rises the cycle after the posedge that accepts `load_done`.
- Read latency: a request sampled at posedge N gives valid data after posedge N; it is stable through cycle N+1 for consumers sampling at the following negedge.
- Write latency: a write sampled at posedge N is visible to reads sampled at posedge N+1.
- Back-to-back requests every cycle on all ports are supported; there is no backpressure and no stall output.

## Structure
- Shared package `pdp8_pkg` holds `ADDR_WIDTH`, `DATA_WIDTH`, `START_ADDRESS` (o200) and the `mem_state_e` enum {CLEAR, LOAD, RUN}. The enum lives there so checkers can reference it.
- One sub-module, `pdp8_mem_array`: a 2**ADDR_WIDTH x DATA_WIDTH array with one write port and two synchronous read ports, read-before-write. The FSM, sweep counter, write-source mux (sweep / load / exec) and error logic live in the top.

## Test plan
- Reset, then release: `mem_ready` stays 0 for 4096 cycles, and the FSM is LOAD at cycle 4096. Then pulse `load_done` → `mem_ready`=1 the next cycle.
- Load o200=12'o7402 and o7777=12'o1234, then `load_done`. `ifu_rd_req` at o200 → `ifu_rd_data`=12'o7402 one cycle later. `exec_rd_req` at o7777 in the same cycle → `exec_rd_data`=12'o1234.
- In RUN, same cycle: `exec_wr_req` o300=12'o5555 and `ifu_rd_req` o300 → `ifu_rd_data`=0 (old value). Repeat the read next cycle → 12'o5555.
- `ifu_rd_req` during CLEAR and `exec_wr_req` during LOAD → `req_err` pulses one cycle each, read data stays 0, and a later RUN read of the targeted address returns the loaded or cleared value.
- Reset asserted mid-LOAD after o200=12'o7402 → outputs 0 immediately, 4096-cycle sweep reruns, and the o200 read after the new load phase returns 0.
- Loaded word not re-read: load o201=12'o1111 and `load_done`, no reads issued → `ifu_rd_data` holds the last value until the next `ifu_rd_req`.
